rp_wb_sched: RTL and testbench

RP_WB_SCHED -- requirements
Module: rp_wb_sched

---
 rtl/rp_wb_sched.sv | 116 +++++++++++
 tb/tb_rp_wb_sched.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rp_wb_sched.sv
// Writeback scheduler: round-robin arbitration between the ALU (wb0) and LSU
// (wb1) writeback requests onto a single GPR write port, a one-entry output
// stage, and a load-destination scoreboard that drives the decode read-hazard
// stall.
module rp_wb_sched #(
  parameter int AW = 5,
  parameter int XW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          iss_vld,
  output logic          iss_rdy,
  input  logic [AW-1:0] iss_rd,
  input  logic          wb0_vld,
  output logic          wb0_rdy,
  input  logic [AW-1:0] wb0_a,
  input  logic [XW-1:0] wb0_d,
  input  logic          wb1_vld,
  output logic          wb1_rdy,
  input  logic [AW-1:0] wb1_a,
  input  logic [XW-1:0] wb1_d,
  output logic          e_rd,
  output logic [AW-1:0] a_rd,
  output logic [XW-1:0] d_rd,
  input  logic          e_rs1,
  input  logic          e_rs2,
  input  logic [AW-1:0] a_rs1,
  input  logic [AW-1:0] a_rs2,
  output logic          hzd
);

  localparam int NR = 1 << AW;

  logic          lg_q, lg_d;
  logic          ov_q, ov_d;
  logic [AW-1:0] oa_q, oa_d;
  logic [XW-1:0] od_q, od_d;
  logic          os_q, os_d;
  logic [NR-1:1] busy_q, busy_d;

  logic [NR-1:0] busy_vec;
  logic          g0, g1, wb_hs;
  logic          iss_hs, clr_en;
  logic          hz1, hz2;

  // x0 is never busy: view the scoreboard with a hard zero at index 0
  assign busy_vec = {busy_q, 1'b0};

  // Round-robin grant: on contention the source that did not win last time wins
  always_comb begin
    g0    = wb0_vld & (~wb1_vld | lg_q);
    g1    = wb1_vld & (~wb0_vld | ~lg_q);
    wb_hs = g0 | g1;
  end

  assign wb0_rdy = g0;
  assign wb1_rdy = g1;

  // Output stage always accepts; payload only reloads on a completed handshake
  always_comb begin
    ov_d = wb_hs;
    oa_d = oa_q;
    od_d = od_q;
    os_d = os_q;
    lg_d = lg_q;
    if (wb_hs) begin
      oa_d = g1 ? wb1_a : wb0_a;
      od_d = g1 ? wb1_d : wb0_d;
      os_d = g1;
      lg_d = g1;
    end
  end

  // Scoreboard: loads set on issue, LSU commits clear; a set wins over a clear
  always_comb begin
    iss_rdy = (iss_rd == '0) | ~busy_vec[iss_rd];
    iss_hs  = iss_vld & iss_rdy & (iss_rd != '0);
    clr_en  = ov_q & os_q & (oa_q != '0);
    busy_d  = busy_q;
    for (int i = 1; i < NR; i++) begin
      if (clr_en && (oa_q == AW'(i))) busy_d[i] = 1'b0;
      if (iss_hs && (iss_rd == AW'(i))) busy_d[i] = 1'b1;
    end
  end

  // Read hazard: pending load, or a write still sitting in the output stage
  always_comb begin
    hz1 = e_rs1 & (a_rs1 != '0) & (busy_vec[a_rs1] | (ov_q & (oa_q == a_rs1)));
    hz2 = e_rs2 & (a_rs2 != '0) & (busy_vec[a_rs2] | (ov_q & (oa_q == a_rs2)));
    hzd = hz1 | hz2;
  end

  assign e_rd = ov_q & (oa_q != '0);
  assign a_rd = oa_q;
  assign d_rd = od_q;

  // State registers; reset flushes the output stage and the whole scoreboard
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lg_q   <= 1'b1;
      ov_q   <= 1'b0;
      oa_q   <= '0;
      od_q   <= '0;
      os_q   <= 1'b0;
      busy_q <= '0;
    end else begin
      lg_q   <= lg_d;
      ov_q   <= ov_d;
      oa_q   <= oa_d;
      od_q   <= od_d;
      os_q   <= os_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_rp_wb_sched.sv
module tb_rp_wb_sched;

  localparam int AW = 5;
  localparam int XW = 32;
  localparam int NR = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          iss_vld = 1'b0;
  logic          iss_rdy;
  logic [AW-1:0] iss_rd = '0;
  logic          wb0_vld = 1'b0;
  logic          wb0_rdy;
  logic [AW-1:0] wb0_a = '0;
  logic [XW-1:0] wb0_d = '0;
  logic          wb1_vld = 1'b0;
  logic          wb1_rdy;
  logic [AW-1:0] wb1_a = '0;
  logic [XW-1:0] wb1_d = '0;
  logic          e_rd;
  logic [AW-1:0] a_rd;
  logic [XW-1:0] d_rd;
  logic          e_rs1 = 1'b0;
  logic          e_rs2 = 1'b0;
  logic [AW-1:0] a_rs1 = '0;
  logic [AW-1:0] a_rs2 = '0;
  logic          hzd;

  int checks = 0;
  int failures = 0;

  rp_wb_sched #(.AW(AW), .XW(XW)) dut (
    .clk(clk), .rst(rst),
    .iss_vld(iss_vld), .iss_rdy(iss_rdy), .iss_rd(iss_rd),
    .wb0_vld(wb0_vld), .wb0_rdy(wb0_rdy), .wb0_a(wb0_a), .wb0_d(wb0_d),
    .wb1_vld(wb1_vld), .wb1_rdy(wb1_rdy), .wb1_a(wb1_a), .wb1_d(wb1_d),
    .e_rd(e_rd), .a_rd(a_rd), .d_rd(d_rd),
    .e_rs1(e_rs1), .e_rs2(e_rs2), .a_rs1(a_rs1), .a_rs2(a_rs2),
    .hzd(hzd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_vld = 1'b0; iss_rd = '0;
    wb0_vld = 1'b0; wb0_a = '0; wb0_d = '0;
    wb1_vld = 1'b0; wb1_a = '0; wb1_d = '0;
    e_rs1 = 1'b0; e_rs2 = 1'b0; a_rs1 = '0; a_rs2 = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    wb0_vld = 1'b1; wb0_a = 5'd3; wb0_d = 32'hAAAA5555;
    rst = 1'b1;
    tick();
    tick();
    checks++; if (e_rd !== 1'b0) begin failures++; $display("FAIL rst_e_rd got=%0h exp=0", e_rd); end
    checks++; if (a_rd !== '0) begin failures++; $display("FAIL rst_a_rd got=%0h exp=0", a_rd); end
    checks++; if (d_rd !== '0) begin failures++; $display("FAIL rst_d_rd got=%0h exp=0", d_rd); end
    idle();
    rst = 1'b0;
    iss_rd = AW'($urandom_range(1, NR-1));
    e_rs1 = 1'b1; a_rs1 = AW'($urandom_range(1, NR-1));
    e_rs2 = 1'b1; a_rs2 = AW'($urandom_range(1, NR-1));
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (iss_rdy !== 1'b1) begin failures++; $display("FAIL post_rst_iss_rdy got=%0h exp=1", iss_rdy); end
      checks++; if (hzd !== 1'b0) begin failures++; $display("FAIL post_rst_hzd got=%0h exp=0", hzd); end
      tick();
    end
  endtask

  task automatic test_arb();
    logic [XW-1:0] d0, d1;
    do_reset();
    d0 = $urandom; d1 = $urandom;
    wb0_vld = 1'b1; wb0_a = 5'd3; wb0_d = d0;
    wb1_vld = 1'b1; wb1_a = 5'd4; wb1_d = d1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (wb0_rdy !== (k % 2 == 0)) begin failures++; $display("FAIL arb_wb0_rdy k=%0d got=%0h", k, wb0_rdy); end
      checks++; if (wb1_rdy !== (k % 2 == 1)) begin failures++; $display("FAIL arb_wb1_rdy k=%0d got=%0h", k, wb1_rdy); end
      tick();
      checks++; if (e_rd !== 1'b1) begin failures++; $display("FAIL arb_e_rd k=%0d got=%0h exp=1", k, e_rd); end
      checks++; if (a_rd !== ((k % 2 == 0) ? 5'd3 : 5'd4)) begin failures++; $display("FAIL arb_a_rd k=%0d got=%0d", k, a_rd); end
      checks++; if (d_rd !== ((k % 2 == 0) ? d0 : d1)) begin failures++; $display("FAIL arb_d_rd k=%0d got=%0h", k, d_rd); end
    end
    idle();
    #1;
    checks++; if ({wb0_rdy, wb1_rdy} !== 2'b00) begin failures++; $display("FAIL arb_idle_rdy got=%b exp=00", {wb0_rdy, wb1_rdy}); end
    tick();
    checks++; if (e_rd !== 1'b0) begin failures++; $display("FAIL arb_drain_e_rd got=%0h exp=0", e_rd); end
  endtask

  task automatic test_lsu_hazard();
    do_reset();
    iss_vld = 1'b1; iss_rd = 5'd5;
    #1;
    checks++; if (iss_rdy !== 1'b1) begin failures++; $display("FAIL lsu_iss_rdy got=%0h exp=1", iss_rdy); end
    tick();
    iss_vld = 1'b0;
    e_rs1 = 1'b1; a_rs1 = 5'd5;
    #1;
    checks++; if (hzd !== 1'b1) begin failures++; $display("FAIL lsu_hzd_busy got=%0h exp=1", hzd); end
    checks++; if (iss_rdy !== 1'b0) begin failures++; $display("FAIL lsu_iss_blocked got=%0h exp=0", iss_rdy); end
    wb1_vld = 1'b1; wb1_a = 5'd5; wb1_d = 32'hDEADBEEF;
    #1;
    checks++; if ({wb0_rdy, wb1_rdy} !== 2'b01) begin failures++; $display("FAIL lsu_rdy got=%b exp=01", {wb0_rdy, wb1_rdy}); end
    tick();
    wb1_vld = 1'b0;
    #1;
    checks++; if (e_rd !== 1'b1) begin failures++; $display("FAIL lsu_e_rd got=%0h exp=1", e_rd); end
    checks++; if (a_rd !== 5'd5) begin failures++; $display("FAIL lsu_a_rd got=%0d exp=5", a_rd); end
    checks++; if (d_rd !== 32'hDEADBEEF) begin failures++; $display("FAIL lsu_d_rd got=%0h exp=deadbeef", d_rd); end
    checks++; if (hzd !== 1'b1) begin failures++; $display("FAIL lsu_hzd_commit got=%0h exp=1", hzd); end
    tick();
    checks++; if (hzd !== 1'b0) begin failures++; $display("FAIL lsu_hzd_clear got=%0h exp=0", hzd); end
    checks++; if (iss_rdy !== 1'b1) begin failures++; $display("FAIL lsu_busy_clear got=%0h exp=1", iss_rdy); end
  endtask

  task automatic test_reissue();
    do_reset();
    iss_vld = 1'b1; iss_rd = 5'd7;
    tick();
    #1;
    checks++; if (iss_rdy !== 1'b0) begin failures++; $display("FAIL reiss_blocked got=%0h exp=0", iss_rdy); end
    wb1_vld = 1'b1; wb1_a = 5'd7; wb1_d = $urandom;
    tick();
    wb1_vld = 1'b0;
    #1;
    checks++; if (iss_rdy !== 1'b0) begin failures++; $display("FAIL reiss_commit_blocked got=%0h exp=0", iss_rdy); end
    tick();
    checks++; if (iss_rdy !== 1'b1) begin failures++; $display("FAIL reiss_free got=%0h exp=1", iss_rdy); end
    tick();
    iss_vld = 1'b0;
    e_rs2 = 1'b1; a_rs2 = 5'd7;
    #1;
    checks++; if (iss_rdy !== 1'b0) begin failures++; $display("FAIL reiss_busy_set got=%0h exp=0", iss_rdy); end
    checks++; if (hzd !== 1'b1) begin failures++; $display("FAIL reiss_hzd got=%0h exp=1", hzd); end
  endtask

  task automatic test_x0();
    int bad;
    do_reset();
    wb0_vld = 1'b1; wb0_a = 5'd0; wb0_d = 32'h1234;
    #1;
    checks++; if (wb0_rdy !== 1'b1) begin failures++; $display("FAIL x0_wb0_rdy got=%0h exp=1", wb0_rdy); end
    tick();
    wb0_vld = 1'b0;
    e_rs1 = 1'b1; a_rs1 = 5'd0;
    iss_vld = 1'b1; iss_rd = 5'd0;
    #1;
    checks++; if (e_rd !== 1'b0) begin failures++; $display("FAIL x0_e_rd got=%0h exp=0", e_rd); end
    checks++; if (hzd !== 1'b0) begin failures++; $display("FAIL x0_hzd got=%0h exp=0", hzd); end
    checks++; if (iss_rdy !== 1'b1) begin failures++; $display("FAIL x0_iss_rdy got=%0h exp=1", iss_rdy); end
    tick();
    iss_vld = 1'b0;
    bad = 0;
    for (int r = 1; r < NR; r++) begin
      iss_rd = AW'(r);
      #1;
      if (iss_rdy !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL x0_no_busy got=%0d_busy exp=0", bad); end
  endtask

  task automatic test_async_reset();
    logic [XW-1:0] d0;
    do_reset();
    iss_vld = 1'b1; iss_rd = 5'd9;
    tick();
    iss_vld = 1'b0;
    wb1_vld = 1'b1; wb1_a = 5'd9; wb1_d = $urandom;
    tick();
    wb1_vld = 1'b0;
    e_rs1 = 1'b1; a_rs1 = 5'd9;
    #1;
    checks++; if ({e_rd, hzd} !== 2'b11) begin failures++; $display("FAIL ares_pre got=%b exp=11", {e_rd, hzd}); end
    #1;
    rst = 1'b1;
    #1;
    iss_rd = 5'd9;
    #0.5;
    checks++; if (e_rd !== 1'b0) begin failures++; $display("FAIL ares_e_rd got=%0h exp=0", e_rd); end
    checks++; if (hzd !== 1'b0) begin failures++; $display("FAIL ares_hzd got=%0h exp=0", hzd); end
    checks++; if (iss_rdy !== 1'b1) begin failures++; $display("FAIL ares_busy9 got=%0h exp=1", iss_rdy); end
    tick();
    rst = 1'b0;
    d0 = $urandom;
    wb0_vld = 1'b1; wb0_a = 5'd11; wb0_d = d0;
    wb1_vld = 1'b1; wb1_a = 5'd12; wb1_d = $urandom;
    #1;
    checks++; if ({wb0_rdy, wb1_rdy} !== 2'b10) begin failures++; $display("FAIL ares_first_grant got=%b exp=10", {wb0_rdy, wb1_rdy}); end
    tick();
    idle();
    checks++; if (a_rd !== 5'd11 || d_rd !== d0) begin failures++; $display("FAIL ares_first_wb got=%0d/%0h exp=11/%0h", a_rd, d_rd, d0); end
  endtask

  // Reference: busy set per register, last winner, and the one write in flight
  task automatic test_random();
    bit            m_busy[NR];
    bit            m_lg, m_ov, m_os;
    int            m_oa;
    logic [XW-1:0] m_od;
    bit            any, src, x_iss, x_hzd, h1, h2;
    int            bad;
    do_reset();
    for (int r = 0; r < NR; r++) m_busy[r] = 0;
    m_lg = 1; m_ov = 0; m_os = 0; m_oa = 0; m_od = '0;
    bad = 0;
    for (int c = 0; c < 500; c++) begin
      iss_vld = 1'($urandom_range(0, 1));
      iss_rd  = AW'($urandom_range(0, 7));
      wb0_vld = ($urandom_range(0, 2) == 0);
      wb0_a   = AW'($urandom_range(0, 7));
      wb0_d   = $urandom;
      wb1_vld = ($urandom_range(0, 2) == 0);
      wb1_a   = AW'($urandom_range(0, 7));
      wb1_d   = $urandom;
      e_rs1   = 1'($urandom_range(0, 1));
      e_rs2   = 1'($urandom_range(0, 1));
      a_rs1   = AW'($urandom_range(0, 7));
      a_rs2   = AW'($urandom_range(0, 7));
      #1;
      any   = wb0_vld || wb1_vld;
      src   = (wb0_vld && wb1_vld) ? !m_lg : wb1_vld;
      x_iss = (iss_rd == 0) || !m_busy[iss_rd];
      h1    = e_rs1 && a_rs1 != 0 && (m_busy[a_rs1] || (m_ov && m_oa == int'(a_rs1)));
      h2    = e_rs2 && a_rs2 != 0 && (m_busy[a_rs2] || (m_ov && m_oa == int'(a_rs2)));
      x_hzd = h1 || h2;
      checks++;
      if (iss_rdy !== x_iss || wb0_rdy !== (any && !src) || wb1_rdy !== (any && src) ||
          hzd !== x_hzd || e_rd !== (m_ov && m_oa != 0) ||
          (m_ov && (int'(a_rd) != m_oa || d_rd !== m_od))) begin
        failures++;
        bad++;
        if (bad <= 5)
          $display("FAIL rand c=%0d got=%b%b%b%b%b/%0d/%0h exp=%b%b%b%b%b/%0d/%0h", c,
                   iss_rdy, wb0_rdy, wb1_rdy, hzd, e_rd, a_rd, d_rd,
                   x_iss, any && !src, any && src, x_hzd, m_ov && m_oa != 0, m_oa, m_od);
      end
      tick();
      if (m_ov && m_os && m_oa != 0) m_busy[m_oa] = 0;
      if (iss_vld && x_iss && iss_rd != 0) m_busy[iss_rd] = 1;
      m_ov = any;
      if (any) begin
        m_oa = src ? int'(wb1_a) : int'(wb0_a);
        m_od = src ? wb1_d : wb0_d;
        m_os = src;
        m_lg = src;
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_arb();
    test_lsu_hazard();
    test_reissue();
    test_x0();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
